// File: rtl/word_serializer.sv
// Parallel-to-serial unloader: takes a SIZE-bit word over valid/ready and streams it out one bit per enabled cycle.
// Latency: first bit on sout the cycle after the accept edge; SIZE enabled cycles per word, back-to-back with no bubble.
// Backpressure: sout_en low freezes all state; in_ready is high only when idle or while the last bit is being consumed.
module word_serializer #(
    parameter int unsigned SIZE      = 32,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] din,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sout_en,
    output logic            sout,
    output logic            sout_valid,
    output logic            sout_last,
    output logic            busy
);

    localparam int unsigned    CW       = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SIZE-1:0] r_shift;
    logic [SIZE-1:0] w_shift_nxt;
    logic [CW-1:0]   r_cnt;

    logic w_shifting;
    logic w_last;
    logic w_advance;
    logic w_ready;
    logic w_accept;
    logic w_out_bit;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = w_shifting && (r_cnt == LAST_CNT);
    assign w_advance  = w_shifting && sout_en;
    // Ready while idle, or while the final bit leaves so the next word lands with no gap.
    assign w_ready    = (r_state == ST_IDLE) || (w_last && sout_en);
    assign w_accept   = in_valid && w_ready;

    // Shift toward the output end, zero-filling behind.
    assign w_shift_nxt = LSB_FIRST ? {1'b0, r_shift[SIZE-1:1]}
                                   : {r_shift[SIZE-2:0], 1'b0};
    assign w_out_bit   = LSB_FIRST ? r_shift[0] : r_shift[SIZE-1];

    // State register; reset drops any word in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave SHIFT only when the last bit goes out without a reload.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last && sout_en && !w_accept) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, otherwise shift and count on each consumed bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= din;
            r_cnt   <= '0;
        end else if (w_advance) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_last ? '0 : (r_cnt + CW'(1));
        end
    end

    // Outputs: serial bit is gated to 0 outside SHIFT.
    always_comb begin
        busy       = w_shifting;
        sout_valid = w_shifting;
        sout_last  = w_last;
        in_ready   = w_ready;
        sout       = w_shifting ? w_out_bit : 1'b0;
    end

endmodule
